// File: rtl/slv_guard_txn_tracker_pkg.sv
// Shared types for the subordinate-guard transaction tracker: slot record,
// FSM states and fault cause encodings.
package slv_guard_trk_pkg;

   // Slot fields are sized for the widest tracker instance; narrower
   // instances zero-extend on write and truncate on read.
   localparam int unsigned SlotIdBits   = 8;
   localparam int unsigned SlotAddrBits = 64;
   localparam int unsigned SlotAgeBits  = 8;
   localparam int unsigned SlotCntBits  = 32;

   localparam logic [1:0] CAUSE_NONE       = 2'b00;
   localparam logic [1:0] CAUSE_TIMEOUT    = 2'b01;
   localparam logic [1:0] CAUSE_UNEXPECTED = 2'b10;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FAULT = 2'd1,
      FLUSH = 2'd2
   } trk_state_e;

   typedef struct packed {
      logic                    valid;
      logic                    timed;
      logic [SlotIdBits-1:0]   id;
      logic [SlotAddrBits-1:0] addr;
      logic [SlotAgeBits-1:0]  age;
      logic [SlotCntBits-1:0]  counter;
   } slot_t;

endpackage

// File: rtl/slv_guard_txn_tracker_if.sv
// Observed request (AW/AR) and response (B/R) handshake signals of one
// AXI direction, as seen by the transaction tracker.
interface slv_guard_txn_tracker_if #(
   parameter int unsigned IdWidth   = 2,
   parameter int unsigned AddrWidth = 32
) ();

   logic                 req_valid;
   logic                 req_ready;
   logic [IdWidth-1:0]   req_id;
   logic [AddrWidth-1:0] req_addr;
   logic                 rsp_valid;
   logic                 rsp_ready;
   logic                 rsp_last;
   logic [IdWidth-1:0]   rsp_id;

   modport master (
      output req_valid, req_ready, req_id, req_addr,
      output rsp_valid, rsp_ready, rsp_last, rsp_id
   );

   modport slave (
      input req_valid, req_ready, req_id, req_addr,
      input rsp_valid, rsp_ready, rsp_last, rsp_id
   );

endinterface

// File: rtl/slv_guard_txn_tracker_prescaler.sv
// Budget tick generator: pulses once every Div enabled cycles, restartable
// with a synchronous clear.
module slv_guard_prescaler #(
   parameter int unsigned Div = 1
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic clear_i,
   input  logic en_i,
   output logic tick_o
);

   localparam int unsigned           CntWidth = (Div > 1) ? $clog2(Div) : 1;
   localparam logic [CntWidth-1:0]   LastCnt  = CntWidth'(Div - 1);

   logic [CntWidth-1:0] cnt_q;

   always_ff @(posedge clk_i) begin
      if (rst_i || clear_i) begin
         cnt_q <= '0;
      end else if (en_i) begin
         cnt_q <= (cnt_q == LastCnt) ? '0 : cnt_q + 1'b1;
      end
   end

   assign tick_o = en_i && (cnt_q == LastCnt);

endmodule

// File: rtl/slv_guard_txn_tracker.sv
// Per-direction transaction budget tracker: slot table with per-ID in-order
// retirement, timeout/unexpected-response detection and a latched fault record.
module slv_guard_txn_tracker
   import slv_guard_trk_pkg::*;
#(
   parameter int unsigned IdWidth      = 2,
   parameter int unsigned AddrWidth    = 32,
   parameter int unsigned MaxTxns      = 4,
   parameter int unsigned MaxTxnsPerId = 2,
   parameter int unsigned BudgetWidth  = 8,
   parameter int unsigned PrescalerDiv = 1
) (
   input  logic                           clk_i,
   input  logic                           rst_i,
   input  logic                           en_i,
   slv_guard_txn_tracker_if.slave         bus,
   input  logic [BudgetWidth-1:0]         budget_i,
   input  logic                           rst_clear_i,
   output logic                           full_o,
   output logic [$clog2(MaxTxns+1)-1:0]   outstanding_o,
   output logic                           irq_o,
   output logic                           rst_req_o,
   output logic [1:0]                     fault_cause_o,
   output logic [IdWidth-1:0]             fault_id_o,
   output logic [AddrWidth-1:0]           fault_addr_o
);

   localparam int unsigned CountWidth = $clog2(MaxTxns + 1);
   localparam int unsigned IdxWidth   = $clog2(MaxTxns);

   trk_state_e state_q, state_d;

   slot_t slots_q [MaxTxns];
   slot_t slots_d [MaxTxns];

   logic [1:0]           cause_q, cause_d;
   logic [IdWidth-1:0]   fault_id_q, fault_id_d;
   logic [AddrWidth-1:0] fault_addr_q, fault_addr_d;
   logic                 irq_q, irq_d;
   logic                 rst_req_q, rst_req_d;

   logic                  tick;
   logic [CountWidth-1:0] valid_cnt;
   logic [CountWidth-1:0] req_id_cnt;
   logic [CountWidth-1:0] new_age;
   logic                  free_found;
   logic [IdxWidth-1:0]   free_idx;
   logic                  hit;
   logic [IdxWidth-1:0]   hit_idx;
   logic                  exp_found;
   logic [IdxWidth-1:0]   exp_idx;
   logic                  retire_fire;
   logic                  retire_ok;
   logic                  unexpected;
   logic                  enq_fire;
   logic                  same_id_retire;

   slv_guard_prescaler #(
      .Div (PrescalerDiv)
   ) u_prescaler (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .clear_i (state_q == FLUSH),
      .en_i    (state_q == IDLE),
      .tick_o  (tick)
   );

   // All table lookups come from registered state, so a slot freed this
   // cycle is never the one handed to a same-cycle enqueue.
   always_comb begin
      valid_cnt  = '0;
      req_id_cnt = '0;
      free_found = 1'b0;
      free_idx   = '0;
      hit        = 1'b0;
      hit_idx    = '0;
      for (int i = 0; i < MaxTxns; i++) begin
         if (slots_q[i].valid) begin
            valid_cnt = valid_cnt + 1'b1;
            if (slots_q[i].id == SlotIdBits'(bus.req_id)) begin
               req_id_cnt = req_id_cnt + 1'b1;
            end
            if ((slots_q[i].id == SlotIdBits'(bus.rsp_id)) && (slots_q[i].age == '0)) begin
               hit     = 1'b1;
               hit_idx = IdxWidth'(i);
            end
         end else if (!free_found) begin
            free_found = 1'b1;
            free_idx   = IdxWidth'(i);
         end
      end
   end

   assign retire_fire    = (state_q == IDLE) && bus.rsp_valid && bus.rsp_ready && bus.rsp_last;
   assign retire_ok      = retire_fire && hit;
   assign unexpected     = retire_fire && !hit;
   assign same_id_retire = retire_ok && (bus.rsp_id == bus.req_id);
   assign new_age        = same_id_retire ? req_id_cnt - 1'b1 : req_id_cnt;

   assign full_o = (valid_cnt == CountWidth'(MaxTxns)) ||
                   (req_id_cnt >= CountWidth'(MaxTxnsPerId)) ||
                   (state_q != IDLE);

   assign enq_fire = (state_q == IDLE) && en_i && bus.req_valid && bus.req_ready && !full_o;

   // An expiring slot that retires in the same cycle is not a timeout.
   always_comb begin
      exp_found = 1'b0;
      exp_idx   = '0;
      for (int i = 0; i < MaxTxns; i++) begin
         if (!exp_found && slots_q[i].valid && slots_q[i].timed &&
             (slots_q[i].counter == '0) &&
             !(retire_ok && (hit_idx == IdxWidth'(i)))) begin
            exp_found = 1'b1;
            exp_idx   = IdxWidth'(i);
         end
      end
   end

   always_comb begin
      state_d      = state_q;
      slots_d      = slots_q;
      cause_d      = cause_q;
      fault_id_d   = fault_id_q;
      fault_addr_d = fault_addr_q;
      irq_d        = irq_q;
      rst_req_d    = rst_req_q;

      case (state_q)
         IDLE: begin
            for (int i = 0; i < MaxTxns; i++) begin
               if (tick && slots_q[i].valid && slots_q[i].timed && (slots_q[i].counter != '0)) begin
                  slots_d[i].counter = slots_q[i].counter - 1'b1;
               end
               if (retire_ok && slots_q[i].valid && (slots_q[i].id == SlotIdBits'(bus.rsp_id))) begin
                  if (hit_idx == IdxWidth'(i)) begin
                     slots_d[i].valid = 1'b0;
                  end else begin
                     slots_d[i].age = slots_q[i].age - 1'b1;
                  end
               end
            end

            if (enq_fire) begin
               slots_d[free_idx].valid   = 1'b1;
               slots_d[free_idx].timed   = (budget_i != '0);
               slots_d[free_idx].id      = SlotIdBits'(bus.req_id);
               slots_d[free_idx].addr    = SlotAddrBits'(bus.req_addr);
               slots_d[free_idx].age     = SlotAgeBits'(new_age);
               slots_d[free_idx].counter = SlotCntBits'(budget_i);
            end

            // Timeouts outrank an unexpected response; lowest slot wins.
            if (exp_found) begin
               state_d      = FAULT;
               cause_d      = CAUSE_TIMEOUT;
               fault_id_d   = slots_q[exp_idx].id[IdWidth-1:0];
               fault_addr_d = slots_q[exp_idx].addr[AddrWidth-1:0];
               irq_d        = 1'b1;
               rst_req_d    = 1'b1;
            end else if (unexpected) begin
               state_d      = FAULT;
               cause_d      = CAUSE_UNEXPECTED;
               fault_id_d   = bus.rsp_id;
               fault_addr_d = '0;
               irq_d        = 1'b1;
               rst_req_d    = 1'b1;
            end
         end

         FAULT: begin
            if (rst_clear_i) begin
               state_d   = FLUSH;
               rst_req_d = 1'b0;
               for (int i = 0; i < MaxTxns; i++) begin
                  slots_d[i] = '0;
               end
            end
         end

         FLUSH: begin
            state_d      = IDLE;
            irq_d        = 1'b0;
            cause_d      = CAUSE_NONE;
            fault_id_d   = '0;
            fault_addr_d = '0;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int i = 0; i < MaxTxns; i++) begin
            slots_q[i] <= '0;
         end
         cause_q      <= CAUSE_NONE;
         fault_id_q   <= '0;
         fault_addr_q <= '0;
         irq_q        <= 1'b0;
         rst_req_q    <= 1'b0;
      end else begin
         for (int i = 0; i < MaxTxns; i++) begin
            slots_q[i] <= slots_d[i];
         end
         cause_q      <= cause_d;
         fault_id_q   <= fault_id_d;
         fault_addr_q <= fault_addr_d;
         irq_q        <= irq_d;
         rst_req_q    <= rst_req_d;
      end
   end

   assign outstanding_o = valid_cnt;
   assign irq_o         = irq_q;
   assign rst_req_o     = rst_req_q;
   assign fault_cause_o = cause_q;
   assign fault_id_o    = fault_id_q;
   assign fault_addr_o  = fault_addr_q;

endmodule
